// File: rtl/l2_mem_ctrl_if.sv
// Request/response bundle between the L2 bus arbiter (master) and the
// L2 memory controller (slave).
interface l2_mem_ctrl_if;
  logic        l2_mem_en;
  logic        l2_mem_wr_en;
  logic [31:0] l2_mem_access_addr;
  logic [31:0] l2_mem_wr_data;
  logic        l2_mem_par_inject;
  logic [31:0] l2_mem_rd_data;
  logic        l2_mem_rd_valid;
  logic        l2_mem_wr_done;
  logic        l2_mem_busy;
  logic        l2_mem_addr_err;
  logic        l2_mem_parity_err;

  modport master (
    output l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data, l2_mem_par_inject,
    input  l2_mem_rd_data, l2_mem_rd_valid, l2_mem_wr_done, l2_mem_busy,
           l2_mem_addr_err, l2_mem_parity_err
  );

  modport slave (
    input  l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data, l2_mem_par_inject,
    output l2_mem_rd_data, l2_mem_rd_valid, l2_mem_wr_done, l2_mem_busy,
           l2_mem_addr_err, l2_mem_parity_err
  );
endinterface

// File: rtl/l2_mem_ctrl.sv
// Single-port L2 word memory with programmable wait states and a request-hold guard.
// Optional per-word even parity is enabled by defining L2_MEM_PARITY_EN.
module l2_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  l2_mem_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        wr_en_reg, wr_en_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wr_data_reg, wr_data_next;
  logic [31:0] rd_data_reg, rd_data_next;
  logic        rd_valid_reg, rd_valid_next;
  logic        wr_done_reg, wr_done_next;
  logic        addr_err_reg, addr_err_next;

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;
  logic        mem_we;
  logic        par_mismatch;
  logic        addr_in_range;
  logic        grant_changed;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;

  assign addr_in_range = (bus.l2_mem_access_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign grant_changed = (bus.l2_mem_wr_en != wr_en_reg) ||
                         (bus.l2_mem_access_addr != addr_reg);
  assign wr_idx = addr_reg[ADDR_WIDTH+1:2];
  // Read the incoming address while idle so the word is already registered
  // by the time DONE is reached, even with zero wait cycles.
  assign rd_idx = (state_reg == IDLE) ? bus.l2_mem_access_addr[ADDR_WIDTH+1:2] : wr_idx;
  assign mem_we = (state_reg == DONE) && wr_en_reg;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= wr_data_reg;
    end
    mem_q <= mem[rd_idx];
  end

`ifdef L2_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q;
  logic par_inj_reg, par_inj_next;
  logic parity_err_reg, parity_err_next;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[wr_idx] <= (^wr_data_reg) ^ par_inj_reg;
    end
    par_q <= par_mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_inj_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      par_inj_reg    <= par_inj_next;
      parity_err_reg <= parity_err_next;
    end
  end

  always_comb begin
    par_inj_next    = par_inj_reg;
    parity_err_next = 1'b0;
    if (state_reg == IDLE && bus.l2_mem_en && addr_in_range) begin
      par_inj_next = bus.l2_mem_par_inject;
    end
    if (state_reg == DONE && !wr_en_reg) begin
      parity_err_next = par_mismatch;
    end
  end

  assign par_mismatch          = (^mem_q) ^ par_q;
  assign bus.l2_mem_parity_err = parity_err_reg;
`else
  logic unused_par_inject;
  assign unused_par_inject     = bus.l2_mem_par_inject;
  assign par_mismatch          = 1'b0;
  assign bus.l2_mem_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      wr_en_reg    <= 1'b0;
      addr_reg     <= 32'd0;
      wr_data_reg  <= 32'd0;
      rd_data_reg  <= 32'd0;
      rd_valid_reg <= 1'b0;
      wr_done_reg  <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wr_en_reg    <= wr_en_next;
      addr_reg     <= addr_next;
      wr_data_reg  <= wr_data_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      wr_done_reg  <= wr_done_next;
      addr_err_reg <= addr_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    wr_en_next    = wr_en_reg;
    addr_next     = addr_reg;
    wr_data_next  = wr_data_reg;
    rd_data_next  = rd_data_reg;
    rd_valid_next = 1'b0;
    wr_done_next  = 1'b0;
    addr_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.l2_mem_en) begin
          // Rejected requests still latch wr_en/addr so HOLD can detect a grant change.
          wr_en_next = bus.l2_mem_wr_en;
          addr_next  = bus.l2_mem_access_addr;
          if (!addr_in_range) begin
            addr_err_next = 1'b1;
            state_next    = HOLD;
          end else begin
            wr_data_next = bus.l2_mem_wr_data;
            if (WAIT_CYCLES > 0) begin
              cnt_next   = WAIT_LOAD;
              state_next = WAIT;
            end else begin
              state_next = DONE;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        if (wr_en_reg) begin
          wr_done_next = 1'b1;
        end else begin
          rd_valid_next = 1'b1;
          rd_data_next  = mem_q;
        end
        state_next = HOLD;
      end
      HOLD: begin
        // A request left asserted after completion must not be serviced twice.
        if (!bus.l2_mem_en || grant_changed) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.l2_mem_rd_data  = rd_data_reg;
  assign bus.l2_mem_rd_valid = rd_valid_reg;
  assign bus.l2_mem_wr_done  = wr_done_reg;
  assign bus.l2_mem_addr_err = addr_err_reg;
  assign bus.l2_mem_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Directed plus randomized checks of l2_mem_ctrl against a word-array reference model.
module tb_l2_mem_ctrl;
  localparam int AW = 10;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] ref_mem [int];
  bit          ref_inj [int];
  int          written_q[$];
  logic [31:0] exp_rd = 32'd0;

  l2_mem_ctrl_if bus();

  l2_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int key_of(input logic [31:0] addr);
    return int'(addr[AW+1:2]);
  endfunction

  function automatic logic exp_parity(input int key);
`ifdef L2_MEM_PARITY_EN
    return ref_inj[key];
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_pulse(input bit want_rd, input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(want_rd ? bus.l2_mem_rd_valid : bus.l2_mem_wr_done) && lat < limit);
  endtask

  // One complete request from IDLE: accept, completion latency, data, release.
  task automatic do_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic inj);
    int lat;
    int key;
    bit in_range;
    in_range = (addr >> (AW + 2)) == 32'd0;
    key = key_of(addr);
    @(negedge clk);
    chk("idle_busy", {31'd0, bus.l2_mem_busy}, 32'd0);
    bus.l2_mem_en          = 1'b1;
    bus.l2_mem_wr_en       = wr;
    bus.l2_mem_access_addr = addr;
    bus.l2_mem_wr_data     = data;
    bus.l2_mem_par_inject  = inj;
    if (!in_range) begin
      @(negedge clk);
      chk("addr_err_pulse", {31'd0, bus.l2_mem_addr_err}, 32'd1);
      chk("addr_err_busy", {31'd0, bus.l2_mem_busy}, 32'd1);
      bus.l2_mem_en = 1'b0;
      for (int i = 0; i < WC + 3; i++) begin
        chk("addr_err_no_resp", {30'd0, bus.l2_mem_rd_valid, bus.l2_mem_wr_done}, 32'd0);
        @(negedge clk);
      end
      chk("addr_err_clear", {31'd0, bus.l2_mem_addr_err}, 32'd0);
      chk("addr_err_rd_data", bus.l2_mem_rd_data, exp_rd);
      $display("[TB] txn %s addr=%h rejected", wr ? "WR" : "RD", addr);
      return;
    end
    wait_pulse(wr == 1'b0, 40, lat);
    chk(wr ? "wr_latency" : "rd_latency", lat, WC + 2);
    if (wr) begin
      ref_mem[key] = data;
      ref_inj[key] = inj;
      written_q.push_back(key);
      chk("wr_no_rd_valid", {31'd0, bus.l2_mem_rd_valid}, 32'd0);
      chk("wr_rd_data_kept", bus.l2_mem_rd_data, exp_rd);
      chk("wr_parity_err", {31'd0, bus.l2_mem_parity_err}, 32'd0);
    end else begin
      exp_rd = ref_mem[key];
      chk("rd_data", bus.l2_mem_rd_data, exp_rd);
      chk("rd_parity_err", {31'd0, bus.l2_mem_parity_err}, {31'd0, exp_parity(key)});
      chk("rd_no_wr_done", {31'd0, bus.l2_mem_wr_done}, 32'd0);
    end
    bus.l2_mem_en = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", {30'd0, bus.l2_mem_rd_valid, bus.l2_mem_wr_done}, 32'd0);
    chk("release_busy", {31'd0, bus.l2_mem_busy}, 32'd0);
    $display("[TB] txn %s addr=%h data=%h inj=%0d lat=%0d",
             wr ? "WR" : "RD", addr, wr ? data : bus.l2_mem_rd_data, inj, lat);
  endtask

  initial begin
    int cnt;
    int lat;
    logic [31:0] a;
    bus.l2_mem_en          = 1'b0;
    bus.l2_mem_wr_en       = 1'b0;
    bus.l2_mem_access_addr = 32'd0;
    bus.l2_mem_wr_data     = 32'd0;
    bus.l2_mem_par_inject  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.l2_mem_busy}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.l2_mem_rd_valid}, 32'd0);
    chk("rst_wr_done", {31'd0, bus.l2_mem_wr_done}, 32'd0);
    chk("rst_addr_err", {31'd0, bus.l2_mem_addr_err}, 32'd0);
    chk("rst_parity_err", {31'd0, bus.l2_mem_parity_err}, 32'd0);
    chk("rst_rd_data", bus.l2_mem_rd_data, 32'd0);
    rst_n = 1'b1;

    // Basic write/read and neighbour word
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 1'b0);
    do_txn(1'b1, 32'h14, 32'h0BADF00D, 1'b0);

    // Held request is serviced once; re-arbitration gives a second service
    @(negedge clk);
    bus.l2_mem_en = 1'b1; bus.l2_mem_wr_en = 1'b0; bus.l2_mem_access_addr = 32'h10;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.l2_mem_rd_valid) cnt++;
    end
    chk("hold_single_rd", cnt, 1);
    bus.l2_mem_en = 1'b0;
    @(negedge clk);
    bus.l2_mem_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.l2_mem_rd_valid) cnt++;
    end
    chk("hold_second_rd", cnt, 1);
    chk("hold_rd_data", bus.l2_mem_rd_data, 32'hDEADBEEF);
    bus.l2_mem_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] txn HOLD-REPEAT addr=00000010 reads=2");

    // Address change while held leaves HOLD and services the new read
    bus.l2_mem_en = 1'b1; bus.l2_mem_access_addr = 32'h10;
    wait_pulse(1'b1, 40, lat);
    chk("switch_first_rd", bus.l2_mem_rd_data, 32'hDEADBEEF);
    bus.l2_mem_access_addr = 32'h14;
    wait_pulse(1'b1, 40, lat);
    chk("switch_lat", lat, WC + 3);
    chk("switch_second_rd", bus.l2_mem_rd_data, 32'h0BADF00D);
    exp_rd = 32'h0BADF00D;
    bus.l2_mem_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] txn RD-SWITCH 00000010->00000014 data=%h", bus.l2_mem_rd_data);

    // Out-of-range request
    do_txn(1'b0, 32'h00001000, 32'h0, 1'b0);

    // Reset mid-WAIT aborts the write
    do_txn(1'b1, 32'h20, 32'hAAAAAAAA, 1'b0);
    do_txn(1'b0, 32'h14, 32'h0, 1'b0);
    @(negedge clk);
    bus.l2_mem_en = 1'b1; bus.l2_mem_wr_en = 1'b1;
    bus.l2_mem_access_addr = 32'h20; bus.l2_mem_wr_data = 32'h12345678;
    @(negedge clk);
    chk("mid_wait_busy", {31'd0, bus.l2_mem_busy}, 32'd1);
    rst_n = 1'b0;
    bus.l2_mem_en = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.l2_mem_busy}, 32'd0);
    chk("arst_rd_data", bus.l2_mem_rd_data, 32'd0);
    chk("arst_pulses", {29'd0, bus.l2_mem_rd_valid, bus.l2_mem_wr_done, bus.l2_mem_addr_err}, 32'd0);
    exp_rd = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] txn RESET-ABORT WR addr=00000020 data=12345678");
    do_txn(1'b0, 32'h20, 32'h0, 1'b0);

    // Parity injection (flags only when the parity build is enabled)
    do_txn(1'b1, 32'h30, 32'h00000001, 1'b1);
    do_txn(1'b0, 32'h30, 32'h0, 1'b0);
    do_txn(1'b1, 32'h34, 32'h00000001, 1'b0);
    do_txn(1'b0, 32'h34, 32'h0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        a = {20'd0, 10'($urandom), 2'($urandom)};
        do_txn(1'b1, a, $urandom, 1'($urandom));
      end else if (sel < 9) begin
        a = {20'd0, 10'(written_q[$urandom_range(0, written_q.size() - 1)]), 2'($urandom)};
        do_txn(1'b0, a, $urandom, 1'($urandom));
      end else begin
        a = {4'($urandom_range(1, 15)), 28'($urandom)};
        do_txn(1'($urandom), a, $urandom, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/l2_mem_ctrl.md
L2_MEM_CTRL -- requirements
Module: l2_mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word-address width; array depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait cycles inserted before each array access; legal range 0..15.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 l2_mem_en  in  1  SHALL be the request-valid input, driven by the upstream L2 bus arbiter.
REQ-006 l2_mem_wr_en  in  1  SHALL select write (1) or read (0) when l2_mem_en=1.
REQ-007 l2_mem_access_addr  in  32  SHALL be the byte address; bits [1:0] ignored.
REQ-008 l2_mem_wr_data  in  32  SHALL be the write data.
REQ-009 l2_mem_par_inject  in  1  SHALL invert the stored parity of the accepted write (test only).
REQ-010 l2_mem_rd_data  out  32  SHALL be the read data, held until the next completed read.
REQ-011 l2_mem_rd_valid  out  1  SHALL pulse for one cycle when l2_mem_rd_data is valid.
REQ-012 l2_mem_wr_done  out  1  SHALL pulse for one cycle when a write has been committed.
REQ-013 l2_mem_busy  out  1  SHALL be high whenever a new request cannot be accepted.
REQ-014 l2_mem_addr_err  out  1  SHALL pulse for one cycle when an out-of-range request is rejected.
REQ-015 l2_mem_parity_err  out  1  SHALL flag a parity mismatch, qualified by l2_mem_rd_valid.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DONE, HOLD; l2_mem_busy=1 in WAIT, DONE and HOLD.
REQ-017 IDLE: on l2_mem_en=1, the block SHALL latch address, wr_en, wr_data and par_inject, and go to WAIT (WAIT_CYCLES>0) or to DONE (WAIT_CYCLES=0).
REQ-018 The wait counter SHALL load WAIT_CYCLES-1 on entry to WAIT, decrement each cycle and leave WAIT for DONE after the cycle in which it is 0.
REQ-019 DONE SHALL last exactly one cycle: a write commits to the array and wr_done=1; a read registers the array word into rd_data and sets rd_valid=1.
REQ-020 Latency: a request accepted at edge N SHALL have rd_valid/wr_done high during the cycle after edge N+WAIT_CYCLES+1.
REQ-021 HOLD SHALL return to IDLE when l2_mem_en=0, or when {l2_mem_wr_en, l2_mem_access_addr} differs from the latched values (arbiter grant change); otherwise it SHALL remain in HOLD.
REQ-022 The word index SHALL be addr[ADDR_WIDTH+1:2]; if addr[31:ADDR_WIDTH+2] is non-zero in IDLE, the block SHALL not access the array, SHALL pulse addr_err for one cycle, and SHALL go to HOLD.
REQ-023 Input changes during WAIT/DONE SHALL be ignored; the latched request completes.
REQ-024 rd_data SHALL not change on writes or rejected requests.

Reset
REQ-025 On rst_n=0 the FSM SHALL go to IDLE immediately; the counter, rd_data, rd_valid, wr_done, addr_err and parity_err SHALL be 0, and busy SHALL be 0.
REQ-026 Reset during WAIT/DONE SHALL abort the request; a write not yet in DONE SHALL not modify the array; array contents are not reset.

Configuration
REQ-027 With L2_MEM_PARITY_EN defined, each word SHALL store an even-parity bit (XOR of wr_data, inverted if par_inject), and a read SHALL set parity_err=1 with rd_valid on mismatch.
REQ-028 Without L2_MEM_PARITY_EN, there SHALL be no parity storage, parity_err SHALL be tied 0, and par_inject SHALL be ignored; all ports SHALL remain present.

Verification
REQ-029 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 at edge N -> wr_done high in cycle after edge N+3; read 0x10 -> rd_data=0xDEADBEEF, rd_valid one cycle.
REQ-030 Hold l2_mem_en=1 with same read address for 10 cycles -> exactly one rd_valid; drop en one cycle, reassert -> second rd_valid.
REQ-031 Read 0x10, then in HOLD switch address to 0x14 with en held -> HOLD->IDLE, second read completes with word at 0x14.
REQ-032 ADDR_WIDTH=10, read 0x00001000 -> addr_err one-cycle pulse, no rd_valid, rd_data unchanged.
REQ-033 Assert rst_n=0 mid-WAIT of write 0x12345678 to 0x20 (after prior 0xAAAAAAAA) -> outputs 0 immediately; read 0x20 -> 0xAAAAAAAA.
REQ-034 L2_MEM_PARITY_EN: write 0x00000001 with par_inject=1, read back -> parity_err=1 with rd_valid; par_inject=0 -> parity_err=0.
